// File: rtl/miyamii_ram_unit.sv
// MIYAMII RAM unit: 4 registers of 16 main + 4 status nibbles,
// chip-selected access, output port and clear-on-reset sweep.
module miyamii_ram_unit #(
   parameter logic [1:0] CHIP_ID = 2'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] ram_addr,
   input  logic        ram_ce,
   input  logic        ram_we,
   input  logic [3:0]  ram_wdata,
   input  logic        use_status,
   input  logic [1:0]  status_sel,
   input  logic        port_we,
   input  logic [3:0]  port_wdata,
   output logic [3:0]  ram_rdata,
   output logic        rd_valid,
   output logic [3:0]  port_out,
   output logic        busy
);

   localparam logic [0:0] CLEAR = 1'b0;
   localparam logic [0:0] IDLE  = 1'b1;
   localparam logic [6:0] LAST  = 7'd79;

   logic [0:0] state;
   logic [6:0] clr_idx;
   logic [3:0] mem [0:79];
   logic       sel;
   logic       idle;
   logic       wr_req;
   logic       rd_req;
   logic       pt_req;
   logic [6:0] tidx;

   assign sel    = (ram_addr[11:8] == 4'd0) && (ram_addr[7:6] == CHIP_ID);
   assign idle   = (state == IDLE);
   assign busy   = (state == CLEAR);
   assign wr_req = idle && sel && ram_ce && ram_we;
   assign rd_req = idle && sel && ram_ce && !ram_we;
   assign pt_req = idle && sel && port_we;

   // Main nibbles live at 0..63, status nibbles at 64..79.
   assign tidx = use_status ? {3'b100, ram_addr[5:4], status_sel}
                            : {1'b0, ram_addr[5:4], ram_addr[3:0]};

   // Sweep FSM: CLEAR walks every nibble once, then parks in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_idx <= 7'd0;
      end else if (state == CLEAR) begin
         clr_idx <= clr_idx + 7'd1;
         if (clr_idx == LAST)
            state <= IDLE;
      end
   end

   // Storage: sweep zeroes one nibble per cycle, else processor writes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR)
            mem[clr_idx] <= 4'd0;
         else if (wr_req)
            mem[tidx] <= ram_wdata;
      end
   end

   // Read path: one-cycle latency, data held between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_rdata <= 4'd0;
         rd_valid  <= 1'b0;
      end else begin
         rd_valid <= rd_req;
         if (rd_req)
            ram_rdata <= mem[tidx];
      end
   end

   // Output port latch, independent of the RAM access.
   always_ff @(posedge clk) begin
      if (rst)
         port_out <= 4'd0;
      else if (pt_req)
         port_out <= port_wdata;
   end

endmodule

// File: tb/tb_miyamii_ram_unit.sv
// Scoreboard bench for miyamii_ram_unit: reads push expectations,
// a monitor pops and compares on every rd_valid pulse.
module tb_miyamii_ram_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] ram_addr;
   logic        ram_ce;
   logic        ram_we;
   logic [3:0]  ram_wdata;
   logic        use_status;
   logic [1:0]  status_sel;
   logic        port_we;
   logic [3:0]  port_wdata;
   logic [3:0]  ram_rdata;
   logic        rd_valid;
   logic [3:0]  port_out;
   logic        busy;

   typedef struct {
      logic [3:0] data;
      int         tag;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   miyamii_ram_unit #(.CHIP_ID(2'd0)) dut (
      .clk(clk), .rst(rst), .ram_addr(ram_addr), .ram_ce(ram_ce),
      .ram_we(ram_we), .ram_wdata(ram_wdata), .use_status(use_status),
      .status_sel(status_sel), .port_we(port_we),
      .port_wdata(port_wdata), .ram_rdata(ram_rdata),
      .rd_valid(rd_valid), .port_out(port_out), .busy(busy)
   );

   always #5 clk = ~clk;

   // Monitor: every rd_valid pulse must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rd_valid === 1'b1) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_rd_valid data=%h (no read pending)",
                        ram_rdata);
            end else begin
               e = q.pop_front();
               if (ram_rdata !== e.data) begin
                  n_bad++;
                  $display("FAIL read_%0d got=%h want=%h",
                           e.tag, ram_rdata, e.data);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      ram_ce  = 1'b0;
      ram_we  = 1'b0;
      port_we = 1'b0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [3:0] d,
                     input logic us, input logic [1:0] ss);
      ram_addr = a; ram_wdata = d; use_status = us; status_sel = ss;
      ram_ce = 1'b1; ram_we = 1'b1;
      step();
      quiet();
   endtask

   task automatic rd(input logic [11:0] a, input logic us,
                     input logic [1:0] ss, input logic [3:0] d,
                     input bit expect_valid, input int tag);
      exp_t e;
      ram_addr = a; use_status = us; status_sel = ss;
      ram_ce = 1'b1; ram_we = 1'b0;
      if (expect_valid) begin
         e.data = d; e.tag = tag;
         q.push_back(e);
      end
      step();
      quiet();
   endtask

   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < 200) begin
         step();
         cycles++;
      end
   endtask

   int cyc;

   initial begin
      quiet();
      rst = 1'b1; ram_addr = '0; ram_wdata = '0;
      use_status = 1'b0; status_sel = '0; port_wdata = '0;
      step(); step();
      check("rst_rdata", {4'd0, ram_rdata}, 8'h00);
      check("rst_valid", {7'd0, rd_valid}, 8'h00);
      check("rst_port", {4'd0, port_out}, 8'h00);
      check("rst_busy", {7'd0, busy}, 8'h01);
      rst = 1'b0;
      wait_idle(cyc);
      check("busy_cycles", cyc[7:0], 8'd80);

      // Every nibble reads 0 after the sweep.
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 16; c++)
            rd({4'h0, 2'b00, r[1:0], c[3:0]}, 1'b0, 2'd0, 4'h0, 1, r*16+c);
      for (int r = 0; r < 4; r++)
         for (int s = 0; s < 4; s++)
            rd({4'h0, 2'b00, r[1:0], 4'h0}, 1'b1, s[1:0], 4'h0, 1,
               64+r*4+s);
      step();

      // Main write/read and neighbour untouched.
      wr(12'h035, 4'hA, 1'b0, 2'd0);
      rd(12'h035, 1'b0, 2'd0, 4'hA, 1, 100);
      rd(12'h034, 1'b0, 2'd0, 4'h0, 1, 101);
      step();
      check("hold_valid", {7'd0, rd_valid}, 8'h00);
      check("hold_data", {4'd0, ram_rdata}, 8'h00);

      // Status write leaves main array alone.
      wr(12'h010, 4'h7, 1'b1, 2'd2);
      rd(12'h01F, 1'b1, 2'd2, 4'h7, 1, 102);
      rd(12'h010, 1'b0, 2'd0, 4'h0, 1, 103);
      rd(12'h010, 1'b1, 2'd1, 4'h0, 1, 104);

      // Other chip: ignored for write, read and port.
      wr(12'h0C0, 4'h5, 1'b0, 2'd0);
      rd(12'h0C0, 1'b0, 2'd0, 4'h0, 0, 0);
      check("nosel_valid", {7'd0, rd_valid}, 8'h00);
      rd(12'h000, 1'b0, 2'd0, 4'h0, 1, 105);
      rd(12'h100, 1'b0, 2'd0, 4'h0, 0, 0);
      check("page_valid", {7'd0, rd_valid}, 8'h00);
      ram_addr = 12'h0C0; port_wdata = 4'h5; port_we = 1'b1;
      step(); quiet();
      check("nosel_port", {4'd0, port_out}, 8'h00);

      // Back-to-back reads with distinct values.
      for (int i = 0; i < 4; i++)
         wr({8'h02, i[3:0]}, 4'(i + 9), 1'b0, 2'd0);
      for (int i = 0; i < 4; i++)
         rd({8'h02, i[3:0]}, 1'b0, 2'd0, 4'(i + 9), 1, 110 + i);

      // Port and write in the same cycle.
      ram_addr = 12'h03F; ram_wdata = 4'hC; use_status = 1'b0;
      ram_ce = 1'b1; ram_we = 1'b1; port_we = 1'b1; port_wdata = 4'h6;
      step(); quiet();
      check("port_same", {4'd0, port_out}, 8'h06);
      rd(12'h03F, 1'b0, 2'd0, 4'hC, 1, 120);

      // Requests during CLEAR are dropped.
      rst = 1'b1; step(); rst = 1'b0;
      step();
      check("clr_busy", {7'd0, busy}, 8'h01);
      ram_addr = 12'h035; ram_wdata = 4'hF; use_status = 1'b0;
      ram_ce = 1'b1; ram_we = 1'b1; port_we = 1'b1; port_wdata = 4'h9;
      step(); quiet();
      rd(12'h035, 1'b0, 2'd0, 4'h0, 0, 0);
      check("clr_rd_drop", {7'd0, rd_valid}, 8'h00);
      wait_idle(cyc);
      check("clr_done", {7'd0, busy}, 8'h00);
      rd(12'h035, 1'b0, 2'd0, 4'h0, 1, 130);
      check("clr_port", {4'd0, port_out}, 8'h00);
      ram_addr = 12'h035; port_we = 1'b1; port_wdata = 4'h9;
      step(); quiet();
      check("idle_port", {4'd0, port_out}, 8'h09);

      // Write, read, then reset on the next cycle with a read pending.
      wr(12'h02A, 4'h3, 1'b0, 2'd0);
      rd(12'h02A, 1'b0, 2'd0, 4'h3, 1, 140);
      ram_addr = 12'h02A; ram_ce = 1'b1; ram_we = 1'b0; rst = 1'b1;
      step(); quiet();
      check("rst_cut_valid", {7'd0, rd_valid}, 8'h00);
      check("rst_cut_port", {4'd0, port_out}, 8'h00);
      rst = 1'b0;
      repeat (30) step();
      rst = 1'b1; step(); rst = 1'b0;
      wait_idle(cyc);
      check("restart_cycles", cyc[7:0], 8'd80);
      rd(12'h02A, 1'b0, 2'd0, 4'h0, 1, 141);
      rd(12'h03F, 1'b0, 2'd0, 4'h0, 1, 142);
      rd(12'h010, 1'b1, 2'd2, 4'h0, 1, 143);
      step(); step();

      check("queue_empty", 8'(q.size()), 8'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/miyamii_ram_unit.md
MIYAMII_RAM_UNIT -- requirements
Module: miyamii_ram_unit

Interface
REQ-001 Parameter: CHIP_ID, default 2'd0, chip number this unit answers to.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 ram_addr  input  12  access address from the processor: [11:8] page, [7:6] chip, [5:4] register, [3:0] character.
REQ-005 ram_ce  input  1  access request, sampled every cycle.
REQ-006 ram_we  input  1  1 = write, 0 = read; meaningful only with ram_ce.
REQ-007 ram_wdata  input  4  write data, from the processor accumulator.
REQ-008 use_status  input  1  1 = target a status character, 0 = a main character.
REQ-009 status_sel  input  2  status character index when use_status=1.
REQ-010 port_we  input  1  output-port write strobe.
REQ-011 port_wdata  input  4  output-port write data.
REQ-012 ram_rdata  output  4  read data, to the processor RAM data input.
REQ-013 rd_valid  output  1  ram_rdata updated this cycle by a read.
REQ-014 port_out  output  4  latched output port.
REQ-015 busy  output  1  clear sweep in progress; all accesses ignored.

Function
REQ-016 Storage: 4 registers x 16 main characters x 4 bits, plus 4 registers x 4 status characters x 4 bits (80 nibbles total).
REQ-017 Select: sel = (ram_addr[11:8]==0) && (ram_addr[7:6]==CHIP_ID); when sel=0 the unit ignores ram_ce and port_we.
REQ-018 Target nibble: register ram_addr[5:4]; main character ram_addr[3:0] when use_status=0; status character status_sel when use_status=1, with ram_addr[3:0] ignored.
REQ-019 FSM states: CLEAR and IDLE; rst forces CLEAR with clr_idx=0.
REQ-020 CLEAR: each cycle writes 0 to linear location clr_idx (0-63 main as reg*16+char; 64-79 status as 64+reg*4+sel), then clr_idx increments.
REQ-021 CLEAR -> IDLE on the edge that clears index 79; busy=1 exactly while in CLEAR, i.e. 80 cycles after rst falls.
REQ-022 IDLE stays IDLE until rst; the FSM has no other transitions.
REQ-023 Write: in IDLE with ram_ce & ram_we & sel, the target nibble takes ram_wdata at that edge; rd_valid=0 the following cycle.
REQ-024 Read: in IDLE with ram_ce & ~ram_we & sel, the following cycle ram_rdata = target nibble and rd_valid=1 (1-cycle latency).
REQ-025 rd_valid is a single-cycle pulse per read; back-to-back reads give consecutive pulses with a new value each cycle.
REQ-026 With no read issued, ram_rdata holds its last value and rd_valid=0.
REQ-027 Write at cycle N followed by a read of the same nibble at N+1 returns the new data.
REQ-028 Port: in IDLE with port_we & sel, port_out takes port_wdata next edge; the port is independent of ram_ce/ram_we and the two may occur in the same cycle.
REQ-029 Any ram_ce or port_we during CLEAR is dropped with no memory, port or rd_valid effect; requests are not queued.
REQ-030 Status and main arrays are disjoint: a status write never alters a main character, and vice versa.

Reset
REQ-031 While rst=1 (synchronous): state=CLEAR, clr_idx=0, ram_rdata=0, rd_valid=0, port_out=0, busy=1.
REQ-032 rst asserted mid-sweep or mid-operation restarts the sweep from index 0; a read issued in the cycle rst is asserted produces no rd_valid.
REQ-033 Memory contents are defined only through the sweep; after busy falls every nibble reads 0.

Verification
REQ-034 Reset pulse, then count cycles -> busy=1 for exactly 80 cycles after rst falls; read of every main and status nibble returns 0, each with one rd_valid pulse.
REQ-035 CHIP_ID=0: write 4'hA to addr 12'h035 (reg3, char5), then read it -> next cycle ram_rdata=4'hA, rd_valid=1; addr 12'h034 still reads 0.
REQ-036 Write 4'h7 with use_status=1, status_sel=2, addr 12'h010 -> reading status reg1 sel2 gives 4'h7; main reg1 char0 reads 0.
REQ-037 Write 4'h5 to addr 12'h0C0 (chip 3) with CHIP_ID=0 -> no effect; rd_valid stays 0 on a read of 12'h0C0; port_we with the same address leaves port_out=0.
REQ-038 During CLEAR issue write 4'hF and port_we 4'h9 -> after busy falls the nibble reads 0 and port_out=0; the same port_we in IDLE gives port_out=4'h9.
REQ-039 Write 4'h3 at cycle N, read the same nibble at N+1, then assert rst at N+2 mid-sweep -> rd_valid=1 with 4'h3 at N+2; after rst the sweep restarts and the nibble reads 0.
